// File: rtl/aznable_cen_gen.sv
// aznable_cen_gen: CH clock-enable dividers sharing phase 0, with pause freeze and divisor updates committed at the cnt_0 wrap.
// Optional turbo (halved divisors) is compiled in with the CEN_TURBO_EN macro.
module aznable_cen_gen #(
  parameter int                  CH       = 2,
  parameter int                  CNT_W    = 8,
  parameter logic [CH*CNT_W-1:0] DIV_INIT = {8'd12, 8'd4}
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic                  pause,
  input  logic                  turbo,
  input  logic                  cfg_wr,
  input  logic [CH*CNT_W-1:0]   cfg_div,
  output logic [CH-1:0]         cen,
  output logic                  cfg_busy,
  output logic                  pause_ack
);

  logic [CH*CNT_W-1:0] r_div;
  logic [CH*CNT_W-1:0] r_pend;
  logic [CNT_W-1:0]    r_cnt [CH];
  logic [CH-1:0]       r_cen;
  logic                r_busy;
  logic                r_ack;

  logic [CNT_W-1:0]    w_eff [CH];
  logic [CH-1:0]       w_last;
  logic                w_wrap;
  logic                w_commit;
  logic                w_turbo_on;
  logic                w_tsw;
  logic                w_clear;

`ifdef CEN_TURBO_EN
  logic r_turbo;

  // Turbo only changes at a cnt_0 wrap, so the switch never splits a period.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)       r_turbo <= 1'b0;
    else if (w_wrap) r_turbo <= turbo;
  end

  assign w_turbo_on = r_turbo;
  assign w_tsw      = w_wrap && (turbo != r_turbo);
`else
  logic w_unused_turbo;
  assign w_unused_turbo = turbo;
  assign w_turbo_on     = 1'b0;
  assign w_tsw          = 1'b0;
`endif

  always_comb begin
    for (int i = 0; i < CH; i++) begin
      w_eff[i] = r_div[i*CNT_W +: CNT_W];
      if (w_turbo_on) w_eff[i] = w_eff[i] >> 1;
      if (w_eff[i] == '0) w_eff[i] = CNT_W'(1);
      w_last[i] = (r_cnt[i] == w_eff[i] - CNT_W'(1));
    end
  end

  assign w_wrap   = w_last[0] && !pause;
  assign w_commit = w_wrap && r_busy;
  assign w_clear  = w_commit || w_tsw;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_div  <= DIV_INIT;
      r_pend <= '0;
      r_cen  <= '0;
      r_busy <= 1'b0;
      r_ack  <= 1'b0;
      for (int i = 0; i < CH; i++) r_cnt[i] <= '0;
    end else begin
      r_ack <= pause;
      if (pause) begin
        r_cen <= '0;
      end else begin
        // cen at the commit edge still reflects the old divisors
        r_cen <= w_last;
        for (int i = 0; i < CH; i++) begin
          if (w_clear || w_last[i]) r_cnt[i] <= '0;
          else                      r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
      if (w_commit) r_div <= r_pend;
      if (cfg_wr) begin
        r_pend <= cfg_div;
        r_busy <= 1'b1;
      end else if (w_commit) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign cen       = r_cen;
  assign cfg_busy  = r_busy;
  assign pause_ack = r_ack;

endmodule

// File: tb/tb_aznable_cen_gen.sv
// Directed bench for aznable_cen_gen: default periods, pause, divisor commit, zero divisor, reset and turbo.
module tb_aznable_cen_gen;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        pause   = 1'b0;
  logic        turbo   = 1'b0;
  logic        cfg_wr  = 1'b0;
  logic [15:0] cfg_div = '0;
  logic [1:0]  cen;
  logic        cfg_busy;
  logic        pause_ack;

  int n_checks = 0;
  int n_fail   = 0;

  aznable_cen_gen dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .pause     (pause),
    .turbo     (turbo),
    .cfg_wr    (cfg_wr),
    .cfg_div   (cfg_div),
    .cen       (cen),
    .cfg_busy  (cfg_busy),
    .pause_ack (pause_ack)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic       pause;
    logic [1:0] exp_cen;
    logic       exp_ack;
  } vec_t;

  vec_t vecs [34];

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string name, input int edge_n, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s edge %0d: got %0h expected %0h", name, edge_n, act, exp);
    end
  endtask

  initial begin
    int  act_cnt;
    int  waited;
    logic [1:0] e_cen;

    // Per-edge expectations: edges 1..34 after reset, pause held on edges 15..24 (cnt_0 frozen at 2).
    act_cnt = 0;
    for (int e = 1; e <= 34; e++) begin
      vecs[e-1].pause   = (e >= 15 && e <= 24);
      vecs[e-1].exp_ack = vecs[e-1].pause;
      if (vecs[e-1].pause) begin
        vecs[e-1].exp_cen = 2'b00;
      end else begin
        act_cnt++;
        vecs[e-1].exp_cen = {(act_cnt % 12) == 0, (act_cnt % 4) == 0};
      end
    end

    #12;
    chk("rst_cen", 0, 8'(cen), 8'h0);
    chk("rst_busy", 0, 8'(cfg_busy), 8'h0);
    chk("rst_ack", 0, 8'(pause_ack), 8'h0);
    @(posedge clk_sys);
    #1;
    reset = 1'b0;

    for (int e = 1; e <= 34; e++) begin
      pause = vecs[e-1].pause;
      step();
      chk("tbl_cen", e, 8'(cen), 8'(vecs[e-1].exp_cen));
      chk("tbl_ack", e, 8'(pause_ack), 8'(vecs[e-1].exp_ack));
    end
    pause = 1'b0;

    // Divisor update {6,3}: the write lands on the edge that moves cnt_0 from 0 to 1.
    cfg_wr  = 1'b1;
    cfg_div = {8'd6, 8'd3};
    for (int e = 35; e <= 38; e++) begin
      step();
      cfg_wr = 1'b0;
      chk("upd_busy", e, 8'(cfg_busy), 8'(e < 38));
      chk("upd_cen", e, 8'(cen), (e == 38) ? 8'h1 : 8'h0);
    end
    for (int e = 39; e <= 50; e++) begin
      step();
      e_cen = {((e - 38) % 6) == 0, ((e - 38) % 3) == 0};
      chk("new_cen", e, 8'(cen), 8'(e_cen));
    end

    // Zero divisor on channel 1 behaves as 1: both bits high every cycle after the commit.
    cfg_wr  = 1'b1;
    cfg_div = {8'd0, 8'd1};
    step();
    cfg_wr = 1'b0;
    chk("zero_busy", 51, 8'(cfg_busy), 8'h1);
    waited = 0;
    while (cfg_busy && waited < 10) begin
      step();
      waited++;
    end
    chk("zero_commit_wait", 51, 8'(cfg_busy), 8'h0);
    chk("zero_commit_edge", 51, 8'(waited), 8'd2);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("zero_cen", 53 + k, 8'(cen), 8'h3);
    end

    // Reset while paused with an update pending.
    pause = 1'b1;
    step();
    cfg_wr  = 1'b1;
    cfg_div = {8'd5, 8'd5};
    step();
    cfg_wr = 1'b0;
    chk("pend_busy", 0, 8'(cfg_busy), 8'h1);
    chk("pend_ack", 0, 8'(pause_ack), 8'h1);
    chk("pend_cen", 0, 8'(cen), 8'h0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_cen", 0, 8'(cen), 8'h0);
    chk("arst_busy", 0, 8'(cfg_busy), 8'h0);
    chk("arst_ack", 0, 8'(pause_ack), 8'h0);
    pause = 1'b0;
    @(posedge clk_sys);
    #1;
    reset = 1'b0;
    for (int e = 1; e <= 24; e++) begin
      step();
      e_cen = {(e % 12) == 0, (e % 4) == 0};
      chk("post_rst_cen", e, 8'(cen), 8'(e_cen));
      chk("post_rst_busy", e, 8'(cfg_busy), 8'h0);
    end

    // Turbo requested from reset release; it takes effect at the first cnt_0 wrap (edge 4).
    reset = 1'b1;
    turbo = 1'b1;
    @(posedge clk_sys);
    #1;
    reset = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      step();
`ifdef CEN_TURBO_EN
      if (e <= 4) e_cen = {1'b0, e == 4};
      else        e_cen = {((e - 4) % 6) == 0, ((e - 4) % 2) == 0};
`else
      e_cen = {(e % 12) == 0, (e % 4) == 0};
`endif
      chk("turbo_cen", e, 8'(cen), 8'(e_cen));
    end
    turbo = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aznable_cen_gen.md
AZNABLE_CEN_GEN -- requirements
Module: aznable_cen_gen

Interface
REQ-001 Parameter CH, default 2: number of clock-enable channels, legal range 1..8.
REQ-002 Parameter CNT_W, default 8: divisor and counter width per channel, legal range 2..16.
REQ-003 Parameter DIV_INIT, default {8'd12, 8'd4}, width CH*CNT_W: reset divisors, channel i in bits [i*CNT_W +: CNT_W].
REQ-004 clk_sys  in  1  system clock; the block uses one clock only.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 pause  in  1  level; high freezes every channel.
REQ-007 turbo  in  1  level; requests halved divisors (see Configuration).
REQ-008 cfg_wr  in  1  single-cycle strobe that loads cfg_div.
REQ-009 cfg_div  in  CH*CNT_W  new divisors, same packing as DIV_INIT.
REQ-010 cen  out  CH  registered clock-enable pulses, one bit per channel.
REQ-011 cfg_busy  out  1  high while a divisor update is pending.
REQ-012 pause_ack  out  1  registered copy of pause, one-cycle delay.

Function
REQ-013 Each channel SHALL hold an effective divisor d_i; a stored value of 0 SHALL be treated as 1.
REQ-014 Each channel SHALL have a counter cnt_i that counts 0..d_i-1 and wraps to 0.
REQ-015 cen[i] SHALL be high for exactly the one cycle after cnt_i equals d_i-1 while not paused, giving one pulse every d_i cycles.
REQ-016 Pulse timing: cen[i] SHALL pulse on rising edges d_i, 2*d_i, and so on after reset release; with d_i=1, cen[i] SHALL be high every cycle.
REQ-017 All channels SHALL share phase 0: after reset or a commit, every pulse of a channel with divisor d_j SHALL coincide with a pulse of channel i whenever d_i divides d_j.
REQ-018 While pause=1, every counter SHALL hold its value and cen SHALL be all-zero from the next edge.
REQ-019 On pause release, counting SHALL resume from the held value, so phase is preserved and no pulse is lost or duplicated.
REQ-020 On cfg_wr=1, cfg_div SHALL be latched into a pending register and cfg_busy SHALL go high on the next edge.
REQ-021 cfg_wr while cfg_busy=1: the pending value SHALL be overwritten (last write wins) and cfg_busy SHALL stay high.
REQ-022 Commit SHALL occur on the edge where cnt_0 wraps while not paused. At that edge: pending becomes active, all counters clear to 0, and cfg_busy falls.
REQ-023 The cen pulses produced at the commit edge SHALL use the old divisors; pulses after it SHALL use the new ones.
REQ-024 cfg_wr on the same edge as a commit SHALL be latched as a new pending value, and cfg_busy SHALL remain high.
REQ-025 While paused, a pending commit SHALL wait; cfg_wr SHALL still be accepted.

Reset
REQ-026 Asserting reset SHALL asynchronously set: cen=0, cfg_busy=0, pause_ack=0, all counters 0, active divisors=DIV_INIT, pending cleared, turbo latch 0.
REQ-027 Reset asserted mid-pause or mid-pending SHALL discard the pause state and the pending update; on release the block SHALL count from 0 with DIV_INIT.

Configuration
REQ-028 Macro CEN_TURBO_EN SHALL compile turbo mode in or out.
REQ-029 With CEN_TURBO_EN defined: turbo SHALL be latched only at a commit edge or a cnt_0 wrap; while the latched turbo is 1, the effective divisor SHALL be max(1, d_i>>1), and counters SHALL clear at the switch.
REQ-030 Without CEN_TURBO_EN: the turbo port SHALL exist but be ignored, and the effective divisor SHALL equal the stored divisor.

Verification
REQ-031 Defaults, no stimulus -> cen[0] pulses at edges 4, 8, 12, ...; cen[1] pulses at edges 12, 24, ...; both bits high together at edge 12.
REQ-032 pause high for 10 cycles starting at cnt_0=2 -> zero pulses during pause; pause_ack follows pause one cycle late; the next cen[0] arrives 2 active cycles after release.
REQ-033 cfg_wr with {8'd6, 8'd3} at cnt_0=1 -> cfg_busy high for 3 cycles; after the commit, cen[0] pulses every 3 cycles and cen[1] every 6 cycles, aligned.
REQ-034 cfg_div={8'd0, 8'd1} -> both cen bits high on every cycle after the commit.
REQ-035 With CEN_TURBO_EN: turbo=1 on default divisors -> after the next cnt_0 wrap, cen[0] pulses every 2 cycles and cen[1] every 6. Without CEN_TURBO_EN: periods stay 4 and 12.
REQ-036 reset pulsed while cfg_busy=1 and pause=1 -> all outputs 0 immediately; after release, periods are 4 and 12 and cfg_busy=0.
